// File: rtl/seq_suma_multinibble.sv
// seq_suma_multinibble: multi-precision adder controller.
// Streams operands one nibble per clock through an external combinational
// 4-bit full-adder chain, ripples the carry through carry_r, and assembles
// a 4*NIBBLES-bit result with carry, signed-overflow and zero flags.
module seq_suma_multinibble #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_s,
  input  logic                   add_cout,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf,
  output logic                   zero
);

  localparam int W = 4 * NIBBLES;

  // FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Index of the most significant nibble (NIBBLES is at most 8)
  localparam logic [2:0] LAST = 3'(NIBBLES - 1);

  logic [1:0]   state;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic         carry_r;
  logic [2:0]   idx;
  logic [4:0]   base;
  logic [W-1:0] result_next;

  // Bit offset of the nibble currently being added
  assign base = {idx, 2'b00};

  // Status is a pure decode of the state register, so it never glitches
  assign busy = (state == ADD);
  assign done = (state == DONE);

  // Present the current operand slice and carry to the adder chain while adding
  always_comb begin
    add_a   = 4'b0000;
    add_b   = 4'b0000;
    add_cin = 1'b0;
    if (state == ADD) begin
      add_a   = a_r[base +: 4];
      add_b   = b_r[base +: 4];
      add_cin = carry_r;
    end else begin
      add_a   = 4'b0000;
      add_b   = 4'b0000;
      add_cin = 1'b0;
    end
  end

  // Result with the freshly computed nibble merged in (used for the zero flag)
  always_comb begin
    result_next = result;
    result_next[base +: 4] = add_s;
  end

  // Sequencer: capture operands, step through nibbles, latch flags on the last one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      carry_r <= 1'b0;
      idx     <= 3'd0;
      result  <= {W{1'b0}};
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= op_a;
            b_r     <= op_b;
            carry_r <= cin;
            idx     <= 3'd0;
            state   <= ADD;
          end else begin
            state   <= IDLE;
          end
        end
        ADD: begin
          result  <= result_next;
          carry_r <= add_cout;
          if (idx == LAST) begin
            cout  <= add_cout;
            // Signed overflow: like-signed operands producing an opposite-signed sum
            ovf   <= (a_r[W-1] == b_r[W-1]) && (add_s[3] != a_r[W-1]);
            zero  <= (result_next == {W{1'b0}});
            idx   <= 3'd0;
            state <= DONE;
          end else begin
            idx   <= idx + 3'd1;
            state <= ADD;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
